// File: rtl/climate_pkg.sv
// Shared definitions for the incubator climate controller: mode encoding and
// signed threshold comparison helpers.
package climate_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_COOL  = 2'd1,
    MODE_HEAT  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_t;

  localparam int FAN_LVL_W = 3;

  // Sample and threshold are both carried as sign-extended ints, so the
  // comparison stays signed regardless of TEMP_W.
  function automatic logic temp_gt(input int sample, input int threshold);
    return sample > threshold;
  endfunction

  function automatic logic temp_lt(input int sample, input int threshold);
    return sample < threshold;
  endfunction

endpackage

// File: rtl/climate_fan_ladder.sv
// Multi-level cooling fan: one step per qualified sample while cooling,
// forced off outside COOL and forced to maximum in FAULT.
module climate_fan_ladder
  import climate_pkg::*;
#(
  parameter int TEMP_W   = 8,
  parameter int FAN_LVLS = 3,
  parameter int FAN_BASE = 35,
  parameter int FAN_STEP = 5,
  parameter int FAN_HYST = 10,
  parameter int DUTY0    = 4,
  parameter int DUTY_INC = 2,
  parameter int DUTY_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 temp_vld,
  input  logic [TEMP_W-1:0]    temp,
  input  mode_t                mode_cur,
  input  mode_t                mode_next,
  output logic [FAN_LVL_W-1:0] fan_lvl,
  output logic [DUTY_W-1:0]    fan_duty
);

  localparam logic [FAN_LVL_W-1:0] LVL_MAX = FAN_LVL_W'(FAN_LVLS);

  logic [FAN_LVL_W-1:0] lvl_reg;
  logic [FAN_LVL_W-1:0] lvl_next;
  int                   temp_int;
  int                   up_th;
  int                   dn_th;
  int                   duty_int;

  assign temp_int = int'($signed(temp));

  always_comb begin
    // up_th enters level lvl+1, dn_th leaves the current level
    up_th = FAN_BASE + int'(lvl_reg) * FAN_STEP;
    dn_th = FAN_BASE + (int'(lvl_reg) - 1) * FAN_STEP - FAN_HYST;
  end

  always_comb begin
    lvl_next = lvl_reg;
    if (mode_next == MODE_FAULT) begin
      lvl_next = LVL_MAX;
    end else if (mode_next != MODE_COOL || mode_cur != MODE_COOL) begin
      // Leaving COOL, or the entry edge into COOL, both land on level 0.
      lvl_next = '0;
    end else if (temp_vld) begin
      if (lvl_reg < LVL_MAX && temp_gt(temp_int, up_th)) begin
        lvl_next = lvl_reg + 1'b1;
      end else if (lvl_reg != '0 && temp_lt(temp_int, dn_th)) begin
        lvl_next = lvl_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_reg <= '0;
    end else begin
      lvl_reg <= lvl_next;
    end
  end

  always_comb begin
    duty_int = 0;
    if (lvl_reg != '0) begin
      duty_int = DUTY0 + (int'(lvl_reg) - 1) * DUTY_INC;
    end
  end

  assign fan_lvl  = lvl_reg;
  assign fan_duty = DUTY_W'(duty_int);

endmodule

// File: rtl/climate_ctrl.sv
// Incubator thermal controller: heat/idle/cool/fault mode FSM with hysteresis
// and a minimum dwell between mode changes; drives heater, cooler and fan.
module climate_ctrl
  import climate_pkg::*;
#(
  parameter int TEMP_W     = 8,
  parameter int T_HOT      = 35,
  parameter int T_HOT_REL  = 25,
  parameter int T_COLD     = 15,
  parameter int T_COLD_REL = 30,
  parameter int T_MIN      = -40,
  parameter int T_MAX      = 100,
  parameter int FAN_LVLS   = 3,
  parameter int FAN_BASE   = 35,
  parameter int FAN_STEP   = 5,
  parameter int FAN_HYST   = 10,
  parameter int DUTY0      = 4,
  parameter int DUTY_INC   = 2,
  parameter int DUTY_W     = 4,
  parameter int DWELL      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp,
  input  logic              temp_vld,
  input  logic              fault_clr,
  output logic              heater,
  output logic              cooler,
  output logic [2:0]        fan_lvl,
  output logic [DUTY_W-1:0] fan_duty,
  output logic              alarm,
  output logic [1:0]        mode
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL);

  mode_t           mode_reg;
  mode_t           mode_next;
  logic [DW_W-1:0] dwell_reg;
  logic            dwell_done;
  logic            out_of_range;
  int              temp_int;

  assign temp_int     = int'($signed(temp));
  assign out_of_range = temp_lt(temp_int, T_MIN) || temp_gt(temp_int, T_MAX);
  assign dwell_done   = (dwell_reg == DWELL_MAX);

  always_comb begin
    mode_next = mode_reg;
    if (temp_vld) begin
      if (out_of_range) begin
        mode_next = MODE_FAULT;
      end else begin
        unique case (mode_reg)
          MODE_IDLE: begin
            if (dwell_done) begin
              if (temp_gt(temp_int, T_HOT)) begin
                mode_next = MODE_COOL;
              end else if (temp_lt(temp_int, T_COLD)) begin
                mode_next = MODE_HEAT;
              end
            end
          end
          MODE_COOL: begin
            if (dwell_done && temp_lt(temp_int, T_HOT_REL)) begin
              mode_next = MODE_IDLE;
            end
          end
          MODE_HEAT: begin
            if (dwell_done && temp_gt(temp_int, T_COLD_REL)) begin
              mode_next = MODE_IDLE;
            end
          end
          MODE_FAULT: begin
            if (fault_clr) begin
              mode_next = MODE_IDLE;
            end
          end
          default: mode_next = MODE_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg <= MODE_IDLE;
    end else begin
      mode_reg <= mode_next;
    end
  end

  // Dwell runs every cycle, independent of temp_vld; reset leaves it expired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_reg <= DWELL_MAX;
    end else if (mode_next != mode_reg) begin
      dwell_reg <= '0;
    end else if (!dwell_done) begin
      dwell_reg <= dwell_reg + 1'b1;
    end
  end

  climate_fan_ladder #(
    .TEMP_W   (TEMP_W),
    .FAN_LVLS (FAN_LVLS),
    .FAN_BASE (FAN_BASE),
    .FAN_STEP (FAN_STEP),
    .FAN_HYST (FAN_HYST),
    .DUTY0    (DUTY0),
    .DUTY_INC (DUTY_INC),
    .DUTY_W   (DUTY_W)
  ) u_fan (
    .clk       (clk),
    .rst       (rst),
    .temp_vld  (temp_vld),
    .temp      (temp),
    .mode_cur  (mode_reg),
    .mode_next (mode_next),
    .fan_lvl   (fan_lvl),
    .fan_duty  (fan_duty)
  );

  assign mode   = mode_reg;
  assign heater = (mode_reg == MODE_HEAT);
  assign cooler = (mode_reg == MODE_COOL);
  assign alarm  = (mode_reg == MODE_FAULT);

endmodule

// File: tb/tb_climate_ctrl.sv
// Directed-vector bench for climate_ctrl with hand-computed expectations
// for modes, fan ladder, dwell, fault handling and asynchronous reset.
module tb_climate_ctrl;

  localparam int DWELL = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] temp = '0;
  logic       temp_vld = 1'b0;
  logic       fault_clr = 1'b0;
  logic       heater;
  logic       cooler;
  logic [2:0] fan_lvl;
  logic [3:0] fan_duty;
  logic       alarm;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  climate_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .temp      (temp),
    .temp_vld  (temp_vld),
    .fault_clr (fault_clr),
    .heater    (heater),
    .cooler    (cooler),
    .fan_lvl   (fan_lvl),
    .fan_duty  (fan_duty),
    .alarm     (alarm),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample at the falling edge, sample outputs 1 after the rising edge.
  task automatic step(input int t, input logic v, input logic clr);
    @(negedge clk);
    temp      = 8'(t);
    temp_vld  = v;
    fault_clr = clr;
    @(posedge clk);
    #1;
    $display("step temp=%0d vld=%0b clr=%0b -> mode=%0d fan=%0d duty=%0d h=%0b c=%0b a=%0b",
             t, v, clr, mode, fan_lvl, fan_duty, heater, cooler, alarm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    temp_vld  = 1'b0;
    fault_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all(input string tag, input int m, input int lvl, input int duty,
                           input int h, input int c, input int a);
    check({tag, "_mode"}, int'(mode), m);
    check({tag, "_fan"}, int'(fan_lvl), lvl);
    check({tag, "_duty"}, int'(fan_duty), duty);
    check({tag, "_heater"}, int'(heater), h);
    check({tag, "_cooler"}, int'(cooler), c);
    check({tag, "_alarm"}, int'(alarm), a);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // COOL entry and fan ramp
    step(40, 1, 0);
    check_all("cool_entry", 1, 0, 0, 0, 1, 0);
    step(40, 1, 0);
    check_all("fan_l1", 1, 1, 4, 0, 1, 0);
    step(36, 1, 0);
    check_all("fan_36", 1, 1, 4, 0, 1, 0);
    step(41, 1, 0);
    check_all("fan_41", 1, 2, 6, 0, 1, 0);
    step(46, 1, 0);
    check_all("fan_46", 1, 3, 8, 0, 1, 0);
    step(51, 1, 0);
    check_all("fan_51_sat", 1, 3, 8, 0, 1, 0);
    step(30, 1, 0);
    check_all("fan_down_30", 1, 2, 6, 0, 1, 0);

    // Asynchronous reset mid-COOL at level 2
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Dwell: COOL must hold for DWELL more cycles before returning to IDLE
    step(40, 1, 0);
    check("dwell_cool_entry", int'(mode), 1);
    for (int i = 1; i <= DWELL; i++) begin
      step(20, 1, 0);
      check($sformatf("dwell_hold_%0d", i), int'(mode), 1);
    end
    step(20, 1, 0);
    check_all("dwell_release", 0, 0, 0, 0, 0, 0);

    // Heat thresholds, fault entry and clear
    do_reset();
    step(35, 1, 0);
    check("idle_35", int'(mode), 0);
    step(15, 1, 0);
    check("idle_15", int'(mode), 0);
    step(14, 1, 0);
    check_all("heat_14", 2, 0, 0, 1, 0, 0);
    step(-50, 1, 0);
    check_all("fault_m50", 3, 3, 8, 0, 0, 1);
    step(20, 1, 0);
    check("fault_no_clr", int'(mode), 3);
    step(101, 1, 1);
    check("fault_clr_oor", int'(mode), 3);
    step(20, 1, 1);
    check_all("fault_cleared", 0, 0, 0, 0, 0, 0);
    step(101, 1, 0);
    check("fault_101_nodwell", int'(mode), 3);
    step(100, 1, 1);
    check("fault_clr_100", int'(mode), 0);
    step(-40, 1, 0);
    check("idle_m40_inrange", int'(mode), 0);
    step(-41, 1, 0);
    check("fault_m41", int'(mode), 3);

    // temp_vld=0 holds state; HEAT dwell and release boundary
    do_reset();
    step(10, 1, 0);
    check("vld_heat", int'(mode), 2);
    for (int i = 0; i < 4; i++) begin
      step(50, 0, 0);
      check($sformatf("vld_low_hold_%0d", i), int'(mode), 2);
      check($sformatf("vld_low_cooler_%0d", i), int'(cooler), 0);
    end
    step(31, 1, 0);
    check("heat_dwell_block", int'(mode), 2);
    for (int i = 0; i < 12; i++) step(50, 0, 0);
    step(30, 1, 0);
    check("heat_30_stay", int'(mode), 2);
    step(31, 1, 0);
    check_all("heat_release_31", 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
